// File: rtl/cordic_rotate_fsm_pkg.sv
// Shared definitions for the rotation-mode and phase-extraction CORDIC blocks:
// controller state encoding, gain-compensated start vector and the pi/2 phase constant.
package cordic_rotate_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITERATE = 2'd1,
        ST_DONE    = 2'd2
    } cordic_state_e;

    // pi/2 in phase units: the full signed phase range spans [-pi, pi).
    function automatic longint cordic_half_pi(input int unsigned phase_w);
        return longint'(1) << (phase_w - 2);
    endfunction

    // Start vector magnitude: full scale pre-multiplied by 1/K (K = CORDIC gain),
    // rounded to nearest, so the rotated vector lands at full scale.
    function automatic longint cordic_x0(input int unsigned out_w);
        longint full_scale;
        full_scale = (longint'(1) << (out_w - 1)) - 1;
        return (full_scale * 64'sd6072529350 + 64'sd5000000000) / 64'sd10000000000;
    endfunction

endpackage

// File: rtl/cordic_sat.sv
// Signed clamp to a symmetric range [-(2^(OUT_W-1)-1), 2^(OUT_W-1)-1].
module cordic_sat #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] MIN_V = -MAX_V;

    // Clamp the wide accumulator into the output width; the most negative code is never produced.
    always_comb begin
        if (in_i > MAX_V) begin
            out_o = MAX_V[OUT_W-1:0];
        end else if (in_i < MIN_V) begin
            out_o = MIN_V[OUT_W-1:0];
        end else begin
            out_o = in_i[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cordic_rotate_fsm.sv
// Iterative rotation-mode CORDIC: computes cos/sin of a signed phase with one
// micro-rotation per clock, controlled by an IDLE/ITERATE/DONE state machine.
module cordic_rotate_fsm
    import cordic_rotate_fsm_pkg::*;
#(
    parameter int PHASE_WIDTH = 26,
    parameter int OUT_WIDTH   = 24,
    parameter int ITERATIONS  = OUT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic signed [PHASE_WIDTH-1:0] phi_i,
    input  logic signed [PHASE_WIDTH-1:0] angle_table_i [ITERATIONS],
    output logic signed [OUT_WIDTH-1:0]   cos_o,
    output logic signed [OUT_WIDTH-1:0]   sin_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int XY_W  = OUT_WIDTH + 2;
    localparam int Z_W   = PHASE_WIDTH + 1;
    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic signed [XY_W-1:0] X0      = XY_W'(cordic_x0(OUT_WIDTH));
    localparam logic signed [Z_W-1:0]  HALF_PI = Z_W'(cordic_half_pi(PHASE_WIDTH));
    localparam logic [CNT_W-1:0]       LAST    = CNT_W'(ITERATIONS - 1);

    cordic_state_e            state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [XY_W-1:0]   x_q, y_q;
    logic signed [Z_W-1:0]    z_q;
    logic signed [OUT_WIDTH-1:0] cos_q, sin_q;
    logic                     busy_q, done_q;

    logic signed [Z_W-1:0]    phi_ext;
    logic signed [XY_W-1:0]   x_init, y_init;
    logic signed [Z_W-1:0]    z_init;
    logic signed [XY_W-1:0]   x_sh, y_sh;
    logic signed [Z_W-1:0]    ang;
    logic signed [XY_W-1:0]   x_d, y_d;
    logic signed [Z_W-1:0]    z_d;
    logic signed [OUT_WIDTH-1:0] cos_sat, sin_sat;

    // Quadrant pre-rotation folds the phase into [-pi/2, pi/2) where CORDIC converges.
    always_comb begin
        phi_ext = {phi_i[PHASE_WIDTH-1], phi_i};
        x_init  = X0;
        y_init  = '0;
        z_init  = phi_ext;
        if (phi_ext >= HALF_PI) begin
            x_init = '0;
            y_init = X0;
            z_init = phi_ext - HALF_PI;
        end else if (phi_ext < -HALF_PI) begin
            x_init = '0;
            y_init = -X0;
            z_init = phi_ext + HALF_PI;
        end
    end

    // One micro-rotation; direction follows the sign of the residual angle.
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        ang  = {angle_table_i[cnt_q][PHASE_WIDTH-1], angle_table_i[cnt_q]};
        if (z_q[Z_W-1] == 1'b0) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - ang;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + ang;
        end
    end

    cordic_sat #(
        .IN_W  (XY_W),
        .OUT_W (OUT_WIDTH)
    ) u_sat_cos (
        .in_i  (x_q),
        .out_o (cos_sat)
    );

    cordic_sat #(
        .IN_W  (XY_W),
        .OUT_W (OUT_WIDTH)
    ) u_sat_sin (
        .in_i  (y_q),
        .out_o (sin_sat)
    );

    // Controller, datapath registers and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_ITERATE;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        x_q     <= x_init;
                        y_q     <= y_init;
                        z_q     <= z_init;
                    end
                end
                ST_ITERATE: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (cnt_q == LAST) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    cos_q   <= cos_sat;
                    sin_q   <= sin_sat;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign cos_o  = cos_q;
    assign sin_o  = sin_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: doc/cordic_rotate_fsm.md
CORDIC_ROTATE_FSM -- requirements
Module: cordic_rotate_fsm

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 26: signed phase width; full range [-2^(PHASE_WIDTH-1), 2^(PHASE_WIDTH-1)-1] maps to [-pi, pi).
REQ-002 SHALL have parameter OUT_WIDTH, default 24: signed sine/cosine output width.
REQ-003 SHALL have parameter ITERATIONS, default OUT_WIDTH: number of CORDIC micro-rotations.
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 reset_i  in  1  asynchronous, active-high reset.
REQ-006 start_i  in  1  request; sampled only in IDLE.
REQ-007 phi_i  in  PHASE_WIDTH signed  target phase; captured on accepted start.
REQ-008 angle_table_i  in  ITERATIONS x PHASE_WIDTH signed  atan(2^-i) in phase units.
REQ-009 cos_o  out  OUT_WIDTH signed  cosine result; held until next completion.
REQ-010 sin_o  out  OUT_WIDTH signed  sine result; held until next completion.
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 done_o  out  1  single-cycle pulse; cos_o/sin_o valid from this cycle.

Function
REQ-013 FSM states SHALL be IDLE, ITERATE, DONE; IDLE->ITERATE on start_i, ITERATE->DONE after ITERATIONS iterations, DONE->IDLE unconditionally.
REQ-014 On accepted start, quadrant pre-rotation: phi_i >= 2^(PHASE_WIDTH-2): x=0, y=+X0, z=phi_i-2^(PHASE_WIDTH-2); phi_i < -2^(PHASE_WIDTH-2): x=0, y=-X0, z=phi_i+2^(PHASE_WIDTH-2); else x=X0, y=0, z=phi_i.
REQ-015 X0 SHALL equal round((2^(OUT_WIDTH-1)-1) x 0.6072529350) (CORDIC gain compensation).
REQ-016 Iteration i (0..ITERATIONS-1), z>=0: x-=y>>>i, y+=x>>>i, z-=angle_table_i[i]; z<0: signs inverted; x/y updates use pre-iteration values.
REQ-017 All ITERATIONS iterations SHALL execute; none skipped.
REQ-018 x, y SHALL be OUT_WIDTH+2 bits signed; z PHASE_WIDTH+1 bits signed; shifts arithmetic.
REQ-019 On entry to DONE, cos_o<=sat(x), sin_o<=sat(y), saturating to [-2^(OUT_WIDTH-1)+1, 2^(OUT_WIDTH-1)-1].
REQ-020 Latency: start sampled at edge E, done_o high in cycle after edge E+ITERATIONS+1; throughput one result per ITERATIONS+2 cycles.
REQ-021 start_i while busy_o high SHALL be ignored (not queued); phi_i changes while busy SHALL not affect result.
REQ-022 start_i held high continuously SHALL restart in the cycle after DONE (IDLE one cycle, captures then).
REQ-023 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-024 reset_i high SHALL force state IDLE, counter 0, x/y/z 0, cos_o=0, sin_o=0, busy_o=0, done_o=0, regardless of clock.
REQ-025 Reset mid-ITERATE or DONE SHALL abort; no done_o pulse for the aborted request.
REQ-026 After reset release, first start_i sampled at next rising edge SHALL be accepted.

Structure
REQ-027 Shared package SHALL hold state enum, X0 computation function, and pi/2 phase constant, reused by the phase-extraction CORDIC.
REQ-028 angle_table_i SHALL be the same table format the phase-extraction CORDIC consumes, so one table instance serves both.
REQ-029 Saturation SHALL be a sub-module cordic_sat (width-parameterized signed clamp), instantiated twice.

Verification (PHASE_WIDTH=26, OUT_WIDTH=24, tolerance +/-16 LSB)
REQ-030 phi_i=0 -> cos_o~8388607, sin_o~0; done_o exactly 25 cycles after start edge.
REQ-031 phi_i=2^23 (pi/4) -> cos_o~sin_o~5931641; phi_i=2^24 (pi/2) -> cos_o~0, sin_o~8388607.
REQ-032 phi_i=-2^25 (-pi) -> cos_o~-8388607, sin_o~0; phi_i=-2^24 -> cos_o~0, sin_o~-8388607.
REQ-033 start_i pulsed during ITERATE with different phi_i -> ignored, single done_o, result of first phi_i.
REQ-034 reset_i asserted at iteration 10 -> outputs 0 immediately, no done_o; new start after release completes normally.
REQ-035 Loopback: 1000 random phi_i -> feed cos_o/sin_o to phase-extraction CORDIC -> recovered phase within +/-64 LSB of phi_i.
